// File: rtl/fir_tdm_mac_if.sv
// Sample, coefficient-write and result signals of fir_tdm_mac, grouped for the source/sink side.
// Parameters must match the fir_tdm_mac instance they are connected to.
interface fir_tdm_mac_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int NCH    = 2
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW   = $clog2(TAPS);

    logic signed [DATA_W-1:0] filter_in;
    logic [CH_W-1:0]          in_ch;
    logic                     in_valid;
    logic                     in_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic signed [DATA_W-1:0] filter_out;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;

    modport master (
        output filter_in, in_ch, in_valid, coef_we, coef_addr, coef_wdata,
        input  in_ready, filter_out, out_ch, out_valid
    );

    modport slave (
        input  filter_in, in_ch, in_valid, coef_we, coef_addr, coef_wdata,
        output in_ready, filter_out, out_ch, out_valid
    );
endinterface

// File: rtl/fir_tdm_mac.sv
// Time-multiplexed FIR: one serial MAC shared by NCH channels, runtime-loadable shared coefficients.
// Define FIR_TDM_SAT_EN to saturate the output; otherwise the rounded result wraps to DATA_W bits.
module fir_tdm_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 16,
    parameter int NCH       = 2,
    parameter int OUT_SHIFT = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_enable,
    fir_tdm_mac_if.slave bus
);
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    localparam logic signed [ACC_W-1:0]  RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << OUT_SHIFT;
`ifdef FIR_TDM_SAT_EN
    localparam logic signed [ACC_W-1:0]  OUT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  OUT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
        return (a + RND_HALF) >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] reduce_out(input logic signed [ACC_W-1:0] r);
`ifdef FIR_TDM_SAT_EN
        if (r > OUT_MAX) return OUT_MAX[DATA_W-1:0];
        if (r < OUT_MIN) return OUT_MIN[DATA_W-1:0];
        return r[DATA_W-1:0];
`else
        return r[DATA_W-1:0];
`endif
    endfunction

    logic [1:0]               state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q [NCH][TAPS];
    logic signed [DATA_W-1:0] x_d [NCH][TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [DATA_W-1:0] filter_out_q, filter_out_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic                     out_valid_q, out_valid_d;

    logic                     in_ready;
    logic                     accept;
    logic                     ch_ok;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        in_ready = (state_q == ST_IDLE) && clk_enable && !bus.coef_we && !reset;
        accept   = in_ready && bus.in_valid;
        ch_ok    = (int'(bus.in_ch) < NCH);
        prod     = PROD_W'(x_q[ch_q][k_q]) * PROD_W'(coef_q[k_q]);

        state_d      = state_q;
        k_d          = k_q;
        ch_d         = ch_q;
        acc_d        = acc_q;
        x_d          = x_q;
        coef_d       = coef_q;
        filter_out_d = filter_out_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;

        if (clk_enable) begin
            out_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.coef_we) begin
                        if (int'(bus.coef_addr) < TAPS) coef_d[bus.coef_addr] = bus.coef_wdata;
                    end else if (accept && ch_ok) begin
                        // x[0] holds the newest sample of each channel
                        for (int i = TAPS - 1; i > 0; i--) x_d[bus.in_ch][i] = x_q[bus.in_ch][i-1];
                        x_d[bus.in_ch][0] = bus.filter_in;
                        ch_d    = bus.in_ch;
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_d = acc_q + ACC_W'(prod);
                    k_d   = k_q + AW'(1);
                    if (k_q == AW'(TAPS - 1)) state_d = ST_ROUND;
                end
                ST_ROUND: begin
                    filter_out_d = reduce_out(round_half_up(acc_q));
                    out_ch_d     = ch_q;
                    out_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Reset restores the identity filter: coef[0] is unity gain after the output shift
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            ch_q    <= '0;
            acc_q   <= '0;
            for (int n = 0; n < NCH; n++)
                for (int i = 0; i < TAPS; i++) x_q[n][i] <= '0;
            for (int i = 0; i < TAPS; i++) coef_q[i] <= (i == 0) ? COEF_ONE : '0;
            filter_out_q <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            ch_q         <= ch_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            coef_q       <= coef_d;
            filter_out_q <= filter_out_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.filter_out = filter_out_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_valid  = out_valid_q;
endmodule
